dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_pkg.sv | 44 ++++
 rtl/dma_rr_arbiter.sv | 48 ++++
 rtl/dma_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_dma_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and encodings for the DMA engine.
// Holds instruction field constants, mode and FSM state enums.
package dma_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] TY_IO  = 2'b01;
  localparam logic [1:0] TY_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_NONE,
    MD_M2IO,
    MD_IO2M,
    MD_M2M
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_ISR_ACK,
    ST_ISR_WR
  } state_e;

  function automatic mode_e decode_mode(
    input logic [1:0] op,
    input logic [1:0] ty
  );
    mode_e m;
    unique case (1'b1)
      op == OP_WR && ty == TY_IO:  m = MD_M2IO;
      op == OP_RD && ty == TY_IO:  m = MD_IO2M;
      op == OP_WR && ty == TY_MEM: m = MD_M2M;
      default:                     m = MD_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin picker for pending I/O interrupts.
// Search starts just after the last serviced channel.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] gnt
);

  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;

  logic [IW-1:0]  last_q;
  logic [IW-1:0]  last_d;
  logic [IW-1:0]  sel;
  logic [NCH-1:0] hi;
  logic [NCH-1:0] pick;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hi[i] = IW'(i) > last_q;
    end
    pick = ((req & hi) != '0) ? (req & hi) : req;
    gnt  = '0;
    sel  = last_q;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        sel    = IW'(i);
      end
    end
    last_d = (advance && req != '0) ? sel : last_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= IW'(NCH - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dma_engine.sv
// Single-bus DMA engine: MEM2IO, IO2MEM, MEM2MEM block copies
// plus round-robin capture of I/O interrupt data into memory.
module dma_engine
  import dma_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int NCH     = 2,
  parameter int IO_BASE = 192,
  parameter int IO_WIN  = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [25:0]    instruction,
  input  logic           start,
  input  logic [AW-1:0]  src_addr,
  input  logic [AW-1:0]  dst_addr,
  input  logic [AW-1:0]  ip_base,
  input  logic [NCH-1:0] io_ip,
  input  logic           grant,
  input  logic [DW-1:0]  rd_data,
  output logic           bus_req,
  output logic           busybus,
  output logic [AW-1:0]  d_address,
  output logic [DW-1:0]  wr_data,
  output logic           d_memwrite,
  output logic [NCH-1:0] d_iowrite,
  output logic [NCH-1:0] d_ioack,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;

  state_e         st_q, st_d;
  mode_e          md_q, md_d;
  logic [AW-1:0]  src_q, src_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [AW-1:0]  cap_q, cap_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [IW-1:0]  ch_q, ch_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic           err_q, err_d;

  mode_e          md_in;
  logic           io_hit;
  logic [IW-1:0]  io_ch;
  logic [NCH-1:0] rr_gnt;
  logic           rr_adv;
  logic [IW-1:0]  rr_ch;
  logic [NCH-1:0] ch_1h;
  logic           unused_ins;

  assign unused_ins = ^instruction[21:6];
  assign md_in = decode_mode(instruction[25:24],
                             instruction[23:22]);

  always_comb begin : io_decode
    int a;
    a = int'((md_in == MD_M2IO) ? dst_addr : src_addr);
    io_hit = a >= IO_BASE && a < IO_BASE + NCH * IO_WIN;
    io_ch  = io_hit ? IW'((a - IO_BASE) / IO_WIN) : '0;
  end

  dma_rr_arbiter #(.NCH(NCH)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (io_ip),
    .advance (rr_adv),
    .gnt     (rr_gnt)
  );

  always_comb begin
    rr_ch = '0;
    ch_1h = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rr_gnt[i]) rr_ch = IW'(i);
      ch_1h[i] = ch_q == IW'(i);
    end
  end

  always_comb begin
    st_d   = st_q;
    md_d   = md_q;
    src_d  = src_q;
    dst_d  = dst_q;
    cap_d  = cap_q;
    cnt_d  = cnt_q;
    ch_d   = ch_q;
    dat_d  = dat_q;
    err_d  = err_q;
    rr_adv = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start && md_in != MD_NONE) begin
          md_d  = md_in;
          src_d = src_addr;
          dst_d = dst_addr;
          cnt_d = instruction[5:0];
          ch_d  = io_ch;
          err_d = 1'b0;
          if (md_in != MD_M2M && !io_hit) begin
            err_d = 1'b1;
            st_d  = ST_DONE;
          end else if (instruction[5:0] == 6'd0) begin
            st_d = ST_DONE;
          end else begin
            st_d = ST_REQ;
          end
        end else if (!start && io_ip != '0) begin
          // MD_NONE marks an interrupt capture in flight
          md_d   = MD_NONE;
          ch_d   = rr_ch;
          rr_adv = 1'b1;
          st_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grant) begin
          st_d = (md_q == MD_NONE) ? ST_ISR_ACK : ST_READ;
        end
      end
      ST_READ: begin
        if (grant) begin
          dat_d = rd_data;
          st_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (grant) begin
          src_d = src_q + AW'(1);
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - 6'd1;
          st_d  = (cnt_q == 6'd1) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      ST_ISR_ACK: begin
        if (grant) begin
          dat_d = rd_data;
          st_d  = ST_ISR_WR;
        end
      end
      ST_ISR_WR: begin
        if (grant) begin
          cap_d = cap_q + AW'(1);
          st_d  = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req    = 1'b0;
    busybus    = 1'b0;
    d_address  = '0;
    wr_data    = '0;
    d_memwrite = 1'b0;
    d_iowrite  = '0;
    d_ioack    = '0;
    unique case (st_q)
      ST_REQ: bus_req = 1'b1;
      ST_READ: begin
        bus_req   = 1'b1;
        busybus   = grant;
        d_address = src_q;
      end
      ST_WRITE: begin
        bus_req   = 1'b1;
        busybus   = grant;
        d_address = dst_q;
        wr_data   = dat_q;
        if (md_q == MD_M2IO) begin
          d_iowrite = grant ? ch_1h : '0;
        end else begin
          d_memwrite = grant;
        end
      end
      ST_ISR_ACK: begin
        bus_req = 1'b1;
        busybus = grant;
        d_ioack = grant ? ch_1h : '0;
      end
      ST_ISR_WR: begin
        bus_req    = 1'b1;
        busybus    = grant;
        d_address  = cap_q;
        wr_data    = dat_q;
        d_memwrite = grant;
      end
      default: ;
    endcase
  end

  assign busy = st_q != ST_IDLE;
  assign done = st_q == ST_DONE;
  assign err  = done & err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q  <= ST_IDLE;
      md_q  <= MD_NONE;
      src_q <= '0;
      dst_q <= '0;
      cap_q <= ip_base;
      cnt_q <= '0;
      ch_q  <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      md_q  <= md_d;
      src_q <= src_d;
      dst_q <= dst_d;
      cap_q <= cap_d;
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Randomized bench for dma_engine against a transaction-level
// model of copies, latency and interrupt capture order.
module tb_dma_engine;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int NCH     = 2;
  localparam int IO_BASE = 192;
  localparam int IO_WIN  = 32;
  localparam logic [3:0] BAD_OP [4] =
    '{4'b0000, 4'b0010, 4'b0111, 4'b1001};

  logic           clock = 1'b0;
  logic           reset;
  logic [25:0]    instruction;
  logic           start;
  logic [AW-1:0]  src_addr;
  logic [AW-1:0]  dst_addr;
  logic [AW-1:0]  ip_base;
  logic [NCH-1:0] io_ip;
  logic           grant;
  logic [DW-1:0]  rd_data;
  logic           bus_req;
  logic           busybus;
  logic [AW-1:0]  d_address;
  logic [DW-1:0]  wr_data;
  logic           d_memwrite;
  logic [NCH-1:0] d_iowrite;
  logic [NCH-1:0] d_ioack;
  logic           busy;
  logic           done;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;
  int rr_last;
  int dcyc;
  logic [AW-1:0] cap;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] dev [NCH];
  int g [300];

  dma_engine #(
    .AW(AW), .DW(DW), .NCH(NCH),
    .IO_BASE(IO_BASE), .IO_WIN(IO_WIN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .ip_base     (ip_base),
    .io_ip       (io_ip),
    .grant       (grant),
    .rd_data     (rd_data),
    .bus_req     (bus_req),
    .busybus     (busybus),
    .d_address   (d_address),
    .wr_data     (wr_data),
    .d_memwrite  (d_memwrite),
    .d_iowrite   (d_iowrite),
    .d_ioack     (d_ioack),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  always_comb begin
    rd_data = mem[d_address];
    for (int i = 0; i < NCH; i++) begin
      if (d_ioack[i]) rd_data = dev[i];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {14'h0, bus_req, busybus, d_address, wr_data,
            d_memwrite, d_iowrite, d_ioack, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    io_ip = '0;
    grant = 1'b0;
    step();
    reset = 1'b0;
    cap = ip_base;
    rr_last = NCH - 1;
    samp();
    chk("reset_outs", outs(), 64'h0);
    step();
  endtask

  task automatic run_xfer(input int md,
                          input logic [AW-1:0] s,
                          input logic [AW-1:0] d,
                          input int n,
                          input int gmode,
                          input logic ipstart,
                          output int gotdone);
    logic [1:0] op, ty;
    logic [5:0] nn;
    logic [2:0] stb;
    logic experr, goterr;
    int a, ch, need, seen, expdone;
    int nbr, nbb, nbusy, nack, stray;
    logic [42:0] exp_w [$];
    logic [42:0] got_w [$];
    logic [AW-1:0] al [300];
    nn = 6'(n);
    case (md)
      1:       begin op = 2'b01; ty = 2'b01; end
      2:       begin op = 2'b00; ty = 2'b01; end
      default: begin op = 2'b01; ty = 2'b10; end
    endcase
    a = (md == 1) ? int'(d) : int'(s);
    experr = (md != 3) &&
             (a < IO_BASE || a >= IO_BASE + NCH * IO_WIN);
    stb = 3'b001;
    if (!experr && md == 1) begin
      ch = (a - IO_BASE) / IO_WIN;
      stb = 3'(1 << (ch + 1));
    end
    if (!experr) begin
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({AW'(int'(d) + i),
                         mem[AW'(int'(s) + i)], stb});
      end
    end
    for (int k = 0; k < 300; k++) begin
      g[k] = 1;
      if (gmode == 1 && k < 100) g[k] = int'($urandom_range(0, 3) != 0);
      if (gmode == 2 && k >= 4 && k <= 6) g[k] = 0;
    end
    expdone = 0;
    if (experr || n == 0) begin
      expdone = 1;
    end else begin
      need = 2 * n + 1;
      seen = 0;
      for (int k = 1; k < 300; k++) begin
        if (g[k] != 0) seen++;
        if (seen == need && expdone == 0) expdone = k + 1;
      end
    end
    instruction = {op, ty, 16'h0, nn};
    src_addr = s;
    dst_addr = d;
    start = 1'b1;
    io_ip = ipstart ? '1 : '0;
    grant = 1'b1;
    gotdone = 0;
    goterr = 1'b0;
    nbr = 0; nbb = 0; nbusy = 0; nack = 0; stray = 0;
    for (int k = 1; k < 299 && gotdone == 0; k++) begin
      step();
      start = (k == 2);
      if (k == 2) instruction = {2'b01, 2'b10, 16'h0, 6'd5};
      io_ip = '0;
      grant = (g[k] != 0);
      samp();
      al[k] = d_address;
      if (d_memwrite || d_iowrite != '0) begin
        got_w.push_back({d_address, wr_data, d_iowrite, d_memwrite});
      end
      if ((d_memwrite || d_iowrite != '0 || d_ioack != '0 ||
           busybus) && !grant) stray++;
      nbr += int'(bus_req);
      nbb += int'(busybus);
      nbusy += int'(busy);
      if (d_ioack != '0) nack++;
      if (done) begin
        gotdone = k;
        goterr = err;
      end
    end
    start = 1'b0;
    chk("done_cycle", gotdone, expdone);
    chk("err", goterr, experr);
    chk("n_writes", got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      chk("write", got_w[i], exp_w[i]);
    end
    chk("stray_strobe", stray, 0);
    chk("bus_req_cycles", nbr,
        (experr || n == 0) ? 0 : expdone - 1);
    chk("busybus_cycles", nbb, experr ? 0 : 2 * n);
    chk("busy_cycles", nbusy, expdone);
    chk("ack_in_xfer", nack, 0);
    if (gmode == 2) begin
      for (int k = 4; k <= 7; k++) begin
        chk("stall_addr", al[k], AW'(int'(s) + 1));
      end
    end
    step();
    samp();
    chk("idle_after", {busy, done}, 0);
    step();
  endtask

  task automatic run_isr(input logic [NCH-1:0] ip, input int nserv);
    logic [NCH-1:0] exp_ack [$];
    logic [NCH-1:0] got_ack [$];
    logic [AW+DW-1:0] exp_w [$];
    logic [AW+DW-1:0] got_w [$];
    int ndone, stray, c;
    ndone = 0;
    stray = 0;
    for (int i = 0; i < NCH; i++) dev[i] = $urandom;
    for (int j = 0; j < nserv; j++) begin
      c = -1;
      for (int i = 1; i <= NCH && c < 0; i++) begin
        if (ip[(rr_last + i) % NCH]) c = (rr_last + i) % NCH;
      end
      rr_last = c;
      exp_ack.push_back(NCH'(1) << c);
      exp_w.push_back({cap, dev[c]});
      cap = cap + AW'(1);
    end
    io_ip = ip;
    start = 1'b0;
    for (int k = 0; k < 400 && got_w.size() < nserv; k++) begin
      grant = ($urandom_range(0, 3) != 0);
      samp();
      if (d_ioack != '0) got_ack.push_back(d_ioack);
      if (d_memwrite) got_w.push_back({d_address, wr_data});
      if ((d_memwrite || d_ioack != '0 || d_iowrite != '0) &&
          !grant) stray++;
      ndone += int'(done);
      step();
    end
    io_ip = '0;
    grant = 1'b1;
    samp();
    chk("isr_idle", busy, 0);
    step();
    chk("isr_n_acks", got_ack.size(), nserv);
    chk("isr_n_writes", got_w.size(), nserv);
    for (int i = 0; i < nserv && i < got_ack.size(); i++) begin
      chk("isr_ack", got_ack[i], exp_ack[i]);
    end
    for (int i = 0; i < nserv && i < got_w.size(); i++) begin
      chk("isr_write", got_w[i], exp_w[i]);
    end
    chk("isr_no_done", ndone, 0);
    chk("isr_stray", stray, 0);
  endtask

  initial begin
    int md, nd;
    logic [AW-1:0] s, d;
    reset = 1'b1;
    instruction = '0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    ip_base = 8'h80;
    io_ip = '0;
    grant = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < NCH; i++) dev[i] = '0;
    step();
    do_reset();

    run_isr(2'b11, 6);

    run_xfer(3, 8'h10, 8'h40, 3, 0, 1'b0, dcyc);
    chk("m2m_done_at_8", dcyc, 8);
    run_xfer(1, 8'h05, 8'hE0, 2, 0, 1'b0, dcyc);
    run_xfer(1, 8'h05, 8'h20, 3, 0, 1'b0, dcyc);
    run_xfer(2, 8'hFE, 8'h30, 3, 0, 1'b0, dcyc);
    run_xfer(2, 8'h10, 8'h30, 2, 0, 1'b0, dcyc);
    run_xfer(3, 8'h50, 8'h70, 2, 2, 1'b0, dcyc);
    chk("stall_done_at_9", dcyc, 9);
    run_xfer(3, 8'h11, 8'h22, 0, 0, 1'b0, dcyc);
    run_xfer(3, 8'hFD, 8'h08, 4, 1, 1'b1, dcyc);

    for (int i = 0; i < 4; i++) begin
      instruction = {BAD_OP[i], 16'h0, 6'd3};
      start = 1'b1;
      step();
      start = 1'b0;
      samp();
      chk("ignore_op", busy, 0);
      step();
    end

    instruction = {2'b01, 2'b10, 16'h0, 6'd4};
    src_addr = 8'h20;
    dst_addr = 8'h60;
    start = 1'b1;
    grant = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    samp();
    chk("pre_rst_write", d_memwrite, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cap = ip_base;
    rr_last = NCH - 1;
    samp();
    chk("rst_mid_outs", outs(), 64'h0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      samp();
      nd += int'(done) + int'(busy);
    end
    chk("rst_quiet", nd, 0);
    step();
    run_xfer(3, 8'h20, 8'h60, 4, 0, 1'b0, dcyc);

    run_isr(2'b10, 2);
    run_isr(2'b01, 2);
    run_isr(2'b11, 3);

    for (int t = 0; t < 40; t++) begin
      md = int'($urandom_range(1, 3));
      s = AW'($urandom);
      d = AW'($urandom);
      if (md != 3 && $urandom_range(0, 3) != 0) begin
        if (md == 1) d = AW'(IO_BASE + int'($urandom_range(0, NCH * IO_WIN - 1)));
        else s = AW'(IO_BASE + int'($urandom_range(0, NCH * IO_WIN - 1)));
      end
      run_xfer(md, s, d, int'($urandom_range(0, 8)), 1,
               1'($urandom_range(0, 1)), dcyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
